// File: rtl/token_pkg.sv
// Shared types and defaults for the doubled-token serial link.
package token_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ODD  = 2'd1,
    EVEN = 2'd2
  } run_state_t;

  localparam int unsigned DEFAULT_MAX_RUN = 400;
  localparam int unsigned DEFAULT_CNT_W   = 16;

endpackage

// File: rtl/run_length_counter.sv
// Saturating run counter with synchronous clear and an "about to exceed LIMIT" strobe.
module run_length_counter #(
  parameter int unsigned LIMIT = 400,
  parameter int unsigned W     = $clog2(LIMIT + 2)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic inc,
  input  logic clr,
  output logic over_c
);

  localparam logic [W-1:0] SAT_VAL = W'(LIMIT + 1);
  localparam logic [W-1:0] LIM_VAL = W'(LIMIT);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en) begin
      if (clr) begin
        count_d = '0;
      end else if (inc && (count_q != SAT_VAL)) begin
        count_d = count_q + W'(1);
      end
    end
  end

  // Fires on the increment that takes the count from LIMIT to LIMIT+1.
  assign over_c = en && inc && !clr && (count_q == LIM_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/halve_tokens.sv
// Serial token decoder: emits one token per pair of ones in each run, with sticky error flags.
module halve_tokens
  import token_pkg::*;
#(
  parameter int unsigned MAX_RUN = DEFAULT_MAX_RUN,
  parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic             in_b,
  output logic             out_vld,
  output logic             out_a,
  output logic [CNT_W-1:0] tokens,
  output logic             odd_err,
  output logic             overflow
);

  run_state_t       state_q, state_d;
  logic             out_vld_q, out_vld_d;
  logic             out_a_q, out_a_d;
  logic [CNT_W-1:0] tokens_q, tokens_d;
  logic             odd_err_q, odd_err_d;
  logic             overflow_q, overflow_d;
  logic             run_over_c;

  run_length_counter #(
    .LIMIT (MAX_RUN)
  ) u_run_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (in_vld),
    .inc    (in_b),
    .clr    (!in_b),
    .over_c (run_over_c)
  );

  always_comb begin
    state_d    = state_q;
    out_vld_d  = in_vld;
    out_a_d    = 1'b0;
    tokens_d   = tokens_q;
    odd_err_d  = odd_err_q;
    overflow_d = overflow_q || run_over_c;
    if (in_vld) begin
      case (state_q)
        IDLE: state_d = in_b ? ODD : IDLE;
        ODD: begin
          if (in_b) begin
            state_d = EVEN;
            out_a_d = 1'b1;
            if (tokens_q != '1) begin
              tokens_d = tokens_q + CNT_W'(1);
            end
          end else begin
            state_d   = IDLE;
            odd_err_d = 1'b1;
          end
        end
        EVEN:    state_d = in_b ? ODD : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      out_vld_q  <= 1'b0;
      out_a_q    <= 1'b0;
      tokens_q   <= '0;
      odd_err_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_vld_q  <= out_vld_d;
      out_a_q    <= out_a_d;
      tokens_q   <= tokens_d;
      odd_err_q  <= odd_err_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_a    = out_a_q;
  assign tokens   = tokens_q;
  assign odd_err  = odd_err_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_halve_tokens.sv
// Scoreboard bench for halve_tokens: a run-parity model predicts each output cycle.
module tb_halve_tokens;

  localparam int MAX_RUN = 400;

  logic        clk, rst_n, in_vld, in_b;
  logic        out_vld, out_a, odd_err, overflow;
  logic [15:0] tokens;
  logic        s_out_vld, s_out_a, s_odd_err, s_overflow;
  logic [3:0]  s_tokens;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entry: {out_vld, out_a, tokens}
  logic [17:0] sb_q[$];
  int          m_run    = 0;
  int          m_tokens = 0;

  halve_tokens #(.MAX_RUN(MAX_RUN), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_b(in_b),
    .out_vld(out_vld), .out_a(out_a), .tokens(tokens),
    .odd_err(odd_err), .overflow(overflow)
  );

  halve_tokens #(.MAX_RUN(MAX_RUN), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_b(in_b),
    .out_vld(s_out_vld), .out_a(s_out_a), .tokens(s_tokens),
    .odd_err(s_odd_err), .overflow(s_overflow)
  );

  always #5 clk = ~clk;

  // Model: a token is emitted on every even-numbered one of a run.
  task automatic drive_cycle(input logic v, input logic b);
    logic ea;
    ea = 1'b0;
    if (v && b) begin
      m_run++;
      ea = ((m_run % 2) == 0);
      if (ea && m_tokens < 65535) m_tokens++;
    end else if (v) begin
      m_run = 0;
    end
    sb_q.push_back({v, ea, 16'(m_tokens)});
    in_vld = v;
    in_b   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_vld = 1'b0;
    in_b   = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    m_run    = 0;
    m_tokens = 0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_vld, out_a, tokens, odd_err, overflow} !== 20'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0", {out_vld, out_a, tokens, odd_err, overflow});
    end
    checks++;
    if ({s_out_vld, s_out_a, s_tokens, s_odd_err, s_overflow} !== 8'h0) begin
      failures++;
      $display("FAIL reset_outputs_sat: got %h want 0", {s_out_vld, s_out_a, s_tokens, s_odd_err, s_overflow});
    end
    do_reset();
  endtask

  task automatic test_vector();
    logic [25:0] pat, want;
    logic [17:0] exp;
    pat  = 26'b11011011110111111001111110;
    want = 26'b01001001010010101000101010;
    for (int i = 25; i >= 0; i--) begin
      drive_cycle(1'b1, pat[i]);
      exp = sb_q.pop_front();
      checks++;
      if ({out_vld, out_a, tokens} !== exp || out_a !== want[i]) begin
        failures++;
        $display("FAIL vector bit %0d: got vld=%b a=%b tok=%0d want vld=%b a=%b tok=%0d",
                 25 - i, out_vld, out_a, tokens, exp[17], want[i], exp[15:0]);
      end
    end
    checks++;
    if (tokens !== 16'd10 || odd_err !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL vector_final: got tok=%0d odd=%b ovf=%b want 10 0 0", tokens, odd_err, overflow);
    end
  endtask

  task automatic test_odd_run();
    logic [6:0]  pat;
    logic [17:0] exp;
    pat = 7'b0111000;
    for (int i = 6; i >= 0; i--) begin
      drive_cycle(1'b1, pat[i]);
      exp = sb_q.pop_front();
      checks++;
      if ({out_vld, out_a, tokens} !== exp) begin
        failures++;
        $display("FAIL odd_stream idx %0d: got %h want %h", 6 - i, {out_vld, out_a, tokens}, exp);
      end
      checks++;
      if (odd_err !== (i <= 2)) begin
        failures++;
        $display("FAIL odd_err_rise idx %0d: got %b want %b", 6 - i, odd_err, (i <= 2));
      end
    end
    for (int k = 0; k < 20; k++) begin
      drive_cycle(1'b1, 1'b0);
      exp = sb_q.pop_front();
      checks++;
      if (odd_err !== 1'b1 || {out_vld, out_a, tokens} !== exp) begin
        failures++;
        $display("FAIL odd_err_sticky idle %0d: got odd=%b out=%h want odd=1 out=%h", k, odd_err, {out_vld, out_a, tokens}, exp);
      end
    end
  endtask

  task automatic test_overflow();
    logic [17:0] exp;
    do_reset();
    for (int n = 0; n < 401; n++) begin
      drive_cycle(1'b1, (n < 400));
      exp = sb_q.pop_front();
      checks++;
      if ({out_vld, out_a, tokens} !== exp) begin
        failures++;
        $display("FAIL run400_stream idx %0d: got %h want %h", n, {out_vld, out_a, tokens}, exp);
      end
    end
    checks++;
    if (tokens !== 16'd200 || overflow !== 1'b0 || odd_err !== 1'b0) begin
      failures++;
      $display("FAIL run400_final: got tok=%0d ovf=%b odd=%b want 200 0 0", tokens, overflow, odd_err);
    end
    for (int n = 1; n <= 402; n++) begin
      drive_cycle(1'b1, (n <= 401));
      exp = sb_q.pop_front();
      checks++;
      if ({out_vld, out_a, tokens} !== exp) begin
        failures++;
        $display("FAIL run401_stream idx %0d: got %h want %h", n, {out_vld, out_a, tokens}, exp);
      end
      if (n == 400 || n == 401) begin
        checks++;
        if (overflow !== (n == 401)) begin
          failures++;
          $display("FAIL overflow_edge after one %0d: got %b want %b", n, overflow, (n == 401));
        end
      end
    end
    checks++;
    if (overflow !== 1'b1 || odd_err !== 1'b1 || tokens !== 16'd400) begin
      failures++;
      $display("FAIL run401_final: got ovf=%b odd=%b tok=%0d want 1 1 400", overflow, odd_err, tokens);
    end
  endtask

  task automatic test_stall();
    logic [17:0] exp;
    int pulses;
    do_reset();
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      if (n == 0 || n == 6) drive_cycle(1'b1, 1'b1);
      else if (n == 7)      drive_cycle(1'b1, 1'b0);
      else                  drive_cycle(1'b0, 1'b1);
      exp = sb_q.pop_front();
      if (out_a === 1'b1) pulses++;
      checks++;
      if ({out_vld, out_a, tokens} !== exp) begin
        failures++;
        $display("FAIL stall_stream idx %0d: got vld=%b a=%b tok=%0d want %h", n, out_vld, out_a, tokens, exp);
      end
    end
    checks++;
    if (pulses !== 1 || odd_err !== 1'b0 || tokens !== 16'd1) begin
      failures++;
      $display("FAIL stall_final: got pulses=%0d odd=%b tok=%0d want 1 0 1", pulses, odd_err, tokens);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [4:0]  pat;
    logic [2:0]  pat2;
    logic [17:0] exp;
    do_reset();
    pat = 5'b10111;
    for (int i = 4; i >= 0; i--) begin
      drive_cycle(1'b1, pat[i]);
      void'(sb_q.pop_front());
    end
    checks++;
    if (odd_err !== 1'b1 || tokens !== 16'd1 || out_vld !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre: got odd=%b tok=%0d vld=%b want 1 1 1", odd_err, tokens, out_vld);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_vld, out_a, tokens, odd_err, overflow} !== 20'h0) begin
      failures++;
      $display("FAIL midrst_async: got %h want 0", {out_vld, out_a, tokens, odd_err, overflow});
    end
    in_vld = 1'b0;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    m_run    = 0;
    m_tokens = 0;
    sb_q.delete();
    pat2 = 3'b110;
    for (int i = 2; i >= 0; i--) begin
      drive_cycle(1'b1, pat2[i]);
      exp = sb_q.pop_front();
      checks++;
      if ({out_vld, out_a, tokens} !== exp) begin
        failures++;
        $display("FAIL midrst_after idx %0d: got %h want %h", 2 - i, {out_vld, out_a, tokens}, exp);
      end
    end
    checks++;
    if (tokens !== 16'd1 || odd_err !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL midrst_final: got tok=%0d odd=%b ovf=%b want 1 0 0", tokens, odd_err, overflow);
    end
  endtask

  task automatic test_saturation();
    logic [17:0] exp;
    do_reset();
    for (int p = 1; p <= 20; p++) begin
      drive_cycle(1'b1, 1'b1);
      void'(sb_q.pop_front());
      drive_cycle(1'b1, 1'b1);
      exp = sb_q.pop_front();
      checks++;
      if ({out_vld, out_a, tokens} !== exp) begin
        failures++;
        $display("FAIL sat_stream pair %0d: got %h want %h", p, {out_vld, out_a, tokens}, exp);
      end
      drive_cycle(1'b1, 1'b0);
      void'(sb_q.pop_front());
      checks++;
      if (s_tokens !== 4'((p < 15) ? p : 15)) begin
        failures++;
        $display("FAIL sat_count pair %0d: got %0d want %0d", p, s_tokens, (p < 15) ? p : 15);
      end
    end
    checks++;
    if (s_tokens !== 4'hF || tokens !== 16'd20 || s_odd_err !== 1'b0 || s_overflow !== 1'b0) begin
      failures++;
      $display("FAIL sat_final: got s_tok=%0d tok=%0d s_odd=%b s_ovf=%b want 15 20 0 0",
               s_tokens, tokens, s_odd_err, s_overflow);
    end
  endtask

  initial begin
    clk    = 1'b0;
    rst_n  = 1'b1;
    in_vld = 1'b0;
    in_b   = 1'b0;
    test_reset();
    test_vector();
    test_odd_run();
    test_overflow();
    test_stall();
    test_reset_mid_run();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/halve_tokens.md
Name: halve_tokens

Overview:
- Serial token decoder and the receive-side counterpart of the token doubler.
- The input is a serial stream in which every token '1' has been doubled. The block emits one token '1' for every second '1' within each maximal run of ones, so the token count is restored.
- Malformed streams are flagged with sticky error flags: an odd-length run sets `odd_err`; an over-long run sets `overflow`.
- Sits at the receive end of the serial token link, after any line register stage. Its output feeds token consumers and statistics.

Parameters:
- MAX_RUN, 400, maximum legal input run length in ones (200 doubled tokens); must be even and at least 2.
- CNT_W, 16, width of the saturating decoded-token counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous, active-low; clears all state
- in_vld  input  1  `in_b` is valid this cycle; when low, all decoder state is held
- in_b  input  1  doubled serial token stream
- out_vld  output  1  registered copy of `in_vld`
- out_a  output  1  decoded token; valid when `out_vld` is high, 0 otherwise
- tokens  output  CNT_W  decoded tokens since reset; saturates at all-ones
- odd_err  output  1  sticky: an odd-length run of ones was seen
- overflow  output  1  sticky: a run longer than MAX_RUN was seen

Behaviour:
- Reset value of every output is 0. Internal reset state: FSM in IDLE, run counter 0.
- All outputs are registered. Latency is 1 cycle: `out_a`/`out_vld` reflect the input sampled on the previous edge.
- Only cycles with `in_vld`=1 advance state. On a cycle with `in_vld`=0:
  - FSM, run counter and `tokens` hold;
  - `out_vld`<=0 and `out_a`<=0.
- FSM states: IDLE (not in a run), ODD (odd count of ones in current run), EVEN (even count, at least 2). Transitions on valid cycles:
  - IDLE: `in_b`=1 -> ODD, `out_a`<=0; `in_b`=0 -> stay IDLE, `out_a`<=0.
  - ODD: `in_b`=1 -> EVEN, `out_a`<=1, `tokens`++ (saturating); `in_b`=0 -> IDLE, `odd_err`<=1, `out_a`<=0.
  - EVEN: `in_b`=1 -> ODD, `out_a`<=0; `in_b`=0 -> IDLE, `out_a`<=0.
- Run counter:
  - width `$clog2(MAX_RUN+2)`;
  - increments on a valid 1 and saturates at MAX_RUN+1;
  - clears on a valid 0.
- `overflow`<=1 on the valid 1 that takes the run counter from MAX_RUN to MAX_RUN+1.
- Decoding continues after `overflow` or `odd_err` is set. Both flags stay set until `rst_n` is asserted.
- An open run at end of stream (no terminating 0) is not an error until a terminating 0 arrives. A stall with `in_vld`=0 does not end a run.
- `tokens` saturates at 2**CNT_W-1 and does not wrap. It is unaffected by the error flags.
- Reset mid-run: the partial run is discarded and no flag is raised. Outputs go to 0 immediately (asynchronous assert). Release is synchronous to `clk` by upstream reset logic.
- Simultaneous overflow and odd-length termination in one run: both flags are set, on their respective cycles.

Decomposition:
- Package `token_pkg`:
  - state enum `run_state_t` {IDLE, ODD, EVEN};
  - constant `DEFAULT_MAX_RUN`=400.
- One sub-module is natural: `run_length_counter`, a saturating counter with a clear input and a `>limit` strobe. It is reused for the run counter; the `tokens` counter stays inline.

Test Plan:
- Reset, then `in_vld`=1 with `in_b` = 11011011110111111001111110 -> `out_a` (1-cycle delayed) = 01001001010010101000101010; `tokens`=10; `odd_err`=0; `overflow`=0.
- Stream 0111000 -> one token on the 2nd 1 of the run; `odd_err` rises on the cycle after the first 0 is sampled and stays 1 through 20 further idle cycles.
- 400 consecutive ones, then a 0 -> `tokens`=200, `overflow`=0. Then 401 ones, then a 0 -> `overflow`=1 one cycle after the 401st 1 is sampled, and `odd_err`=1.
- Stream 1,1 with `in_vld` dropped for 5 cycles between the two 1s -> exactly one `out_a` pulse, no `odd_err`, and `out_vld`=0 during the stall.
- Assert `rst_n`=0 mid-run after three 1s with `odd_err` already set -> all outputs 0 immediately; after release, input 110 gives `tokens`=1 and `odd_err`=0.
- CNT_W=4 with 40 input ones in 2-1 pairs separated by 0s -> `tokens` saturates at 15 and holds.
